// File: rtl/alu_multicycle.sv
// Registered ALU with a valid/ready request port: single-cycle add/sub/logic/shift,
// plus iterative signed multiply and divide that each take WIDTH cycles.
module alu_multicycle #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int OP_W    = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    ctrl_ALUopcode,
  input  logic [SHAMT_W-1:0] ctrl_shiftamt,
  input  logic [WIDTH-1:0]   data_operandA,
  input  logic [WIDTH-1:0]   data_operandB,
  output logic               out_valid,
  output logic [WIDTH-1:0]   data_result,
  output logic               isNotEqual,
  output logic               isLessThan,
  output logic               overflow,
  output logic               exception
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SLL = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SRA = OP_W'(5);
  localparam logic [OP_W-1:0] OP_MUL = OP_W'(6);
  localparam logic [OP_W-1:0] OP_DIV = OP_W'(7);

  localparam logic [SHAMT_W-1:0] LAST_ITER = SHAMT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               ne_q, ne_d, lt_q, lt_d, ov_q, ov_d, exc_q, exc_d;

  function automatic logic [WIDTH-1:0] abs_f(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  // Signed less-than that stays correct when A-B overflows.
  function automatic logic lt_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] diff;
    logic             sub_ov;
    diff   = a - b;
    sub_ov = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    return diff[WIDTH-1] ^ sub_ov;
  endfunction

  // Both iterations work on operand magnitudes; the sign is applied when the result is written.
  logic [WIDTH-1:0]   abs_a, abs_b, mul_lo_n, div_lo_n, quo;
  logic [WIDTH:0]     mul_sum, mul_acc_n, div_rsh, div_acc_n;
  logic               div_ge, neg_res;
  logic [2*WIDTH-1:0] prod_mag, prod;

  assign abs_a     = abs_f(a_q);
  assign abs_b     = abs_f(b_q);
  assign mul_sum   = acc_q + (lo_q[0] ? {1'b0, abs_a} : '0);
  assign mul_acc_n = {1'b0, mul_sum[WIDTH:1]};
  assign mul_lo_n  = {mul_sum[0], lo_q[WIDTH-1:1]};
  assign div_rsh   = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
  assign div_ge    = div_rsh >= {1'b0, abs_b};
  assign div_acc_n = div_ge ? div_rsh - {1'b0, abs_b} : div_rsh;
  assign div_lo_n  = {lo_q[WIDTH-2:0], div_ge};
  assign neg_res   = a_q[WIDTH-1] ^ b_q[WIDTH-1];
  assign prod_mag  = {mul_acc_n[WIDTH-1:0], mul_lo_n};
  assign prod      = neg_res ? -prod_mag : prod_mag;
  assign quo       = neg_res ? -div_lo_n : div_lo_n;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    lo_d        = lo_q;
    out_valid_d = 1'b0;
    result_d    = result_q;
    ne_d        = ne_q;
    lt_d        = lt_q;
    ov_d        = ov_q;
    exc_d       = exc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = data_operandA;
          b_d   = data_operandB;
          acc_d = '0;
          cnt_d = '0;
          case (ctrl_ALUopcode)
            OP_MUL: begin
              state_d = MUL;
              lo_d    = abs_f(data_operandB);
            end
            OP_DIV: begin
              state_d = DIV;
              lo_d    = abs_f(data_operandA);
            end
            default: begin
              out_valid_d = 1'b1;
              ne_d        = data_operandA != data_operandB;
              lt_d        = lt_f(data_operandA, data_operandB);
              ov_d        = 1'b0;
              exc_d       = 1'b0;
              case (ctrl_ALUopcode)
                OP_ADD: begin
                  result_d = data_operandA + data_operandB;
                  ov_d = (data_operandA[WIDTH-1] == data_operandB[WIDTH-1]) &&
                         (result_d[WIDTH-1] != data_operandA[WIDTH-1]);
                end
                OP_SUB: begin
                  result_d = data_operandA - data_operandB;
                  ov_d = (data_operandA[WIDTH-1] != data_operandB[WIDTH-1]) &&
                         (result_d[WIDTH-1] != data_operandA[WIDTH-1]);
                end
                OP_AND:  result_d = data_operandA & data_operandB;
                OP_OR:   result_d = data_operandA | data_operandB;
                OP_SLL:  result_d = data_operandA << ctrl_shiftamt;
                OP_SRA:  result_d = $unsigned($signed(data_operandA) >>> ctrl_shiftamt);
                default: begin
                  result_d = '0;
                  exc_d    = 1'b1;
                end
              endcase
            end
          endcase
        end
      end
      MUL: begin
        acc_d = mul_acc_n;
        lo_d  = mul_lo_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d     = IDLE;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          result_d    = prod[WIDTH-1:0];
          ov_d        = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
          exc_d       = 1'b0;
          ne_d        = a_q != b_q;
          lt_d        = lt_f(a_q, b_q);
        end
      end
      DIV: begin
        acc_d = div_acc_n;
        lo_d  = div_lo_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d     = IDLE;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          ne_d        = a_q != b_q;
          lt_d        = lt_f(a_q, b_q);
          if (b_q == '0) begin
            result_d = '0;
            ov_d     = 1'b0;
            exc_d    = 1'b1;
          end else begin
            result_d = quo;
            ov_d     = (a_q == MIN_VAL) && (b_q == '1);
            exc_d    = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      lo_q        <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ne_q        <= 1'b0;
      lt_q        <= 1'b0;
      ov_q        <= 1'b0;
      exc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      lo_q        <= lo_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ne_q        <= ne_d;
      lt_q        <= lt_d;
      ov_q        <= ov_d;
      exc_q       <= exc_d;
    end
  end

  assign in_ready    = state_q == IDLE;
  assign out_valid   = out_valid_q;
  assign data_result = result_q;
  assign isNotEqual  = ne_q;
  assign isLessThan  = lt_q;
  assign overflow    = ov_q;
  assign exception   = exc_q;

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised, registered successor to the processor's single-cycle combinational ALU.
- Adds signed multiply and divide, each run iteratively over WIDTH cycles.
- Wraps all operations in a valid/ready request interface and a registered response.
- Sits between decode/execute and the writeback latch; the pipeline stalls on in_ready=0.

Parameters:
WIDTH, 32, operand/result width in bits (>=4, power of two)
SHAMT_W, $clog2(WIDTH), width of shift-amount input
OP_W, 5, opcode width

Ports:
clock  input  1  single system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; sampled on rising edge of clock
in_valid  input  1  request present
in_ready  output  1  block can accept a request this cycle
ctrl_ALUopcode  input  OP_W  operation select (encoding below)
ctrl_shiftamt  input  SHAMT_W  shift amount for sll/sra
data_operandA  input  WIDTH  operand A (signed two's complement)
data_operandB  input  WIDTH  operand B (signed two's complement)
out_valid  output  1  one-cycle pulse: result/flags updated
data_result  output  WIDTH  registered result
isNotEqual  output  1  A != B
isLessThan  output  1  A < B, signed, correct even when A-B overflows
overflow  output  1  signed overflow of add/sub/mul, or div MIN/-1
exception  output  1  divide by zero or illegal opcode

Behaviour:
- Opcodes: 00000 add, 00001 sub, 00010 and, 00011 or, 00100 sll, 00101 sra, 00110 mul, 00111 div.
- All other opcodes are illegal.
- Handshake: a request is accepted on a rising edge where in_valid && in_ready.
- Operands and opcode are captured at acceptance; later input changes are ignored.
- No output backpressure: the consumer must take the result on the out_valid pulse.
- data_result and all flags hold their values until the next out_valid.
- FSM states IDLE, MUL, DIV.
- in_ready=1 only in IDLE, including the cycle in which out_valid is high, so back-to-back issue is legal.
- Single-cycle ops (add, sub, and, or, sll, sra, illegal): accepted at edge E, stay in IDLE; out_valid=1 during the cycle after E.
- mul/div: IDLE->MUL/DIV at acceptance edge E.
  - An iteration counter runs 0..WIDTH-1, one iteration per cycle.
  - The FSM returns to IDLE at edge E+WIDTH; out_valid=1 during the following cycle.
  - Total latency is WIDTH cycles.
- add/sub: WIDTH-bit wrap-around. overflow = operand signs equal (B inverted for sub) and result sign differs.
- sll: logical left shift. sra: arithmetic right shift. Both shift A by ctrl_shiftamt; B is ignored.
- mul: signed radix-2 shift-add (Booth permitted) on a 2*WIDTH product.
  - data_result = low WIDTH bits.
  - overflow=1 iff the high WIDTH bits are not the sign extension of bit WIDTH-1.
- div: signed, restoring or non-restoring, quotient truncated toward zero. The remainder is discarded.
  - B==0: data_result=0, exception=1, overflow=0. Still takes the full WIDTH cycles.
  - A==MIN, B==-1: data_result=MIN, overflow=1, exception=0.
- isNotEqual and isLessThan are computed from the captured A and B for every accepted op, including mul/div. isLessThan = sign(A-B) XOR overflow(A-B).
- Flags not defined for an op are 0: overflow for and/or/sll/sra; exception for everything except div-by-zero and illegal opcodes.
- Illegal opcode: data_result=0, exception=1, single-cycle.
- Reset, including mid-operation: at the next edge
  - state=IDLE, counter=0, in_ready=1, out_valid=0
  - data_result=0; isNotEqual, isLessThan, overflow, exception all 0
  - any in-flight mul/div is dropped with no out_valid.
- in_valid while busy: ignored; the request is not consumed and the source must hold it until in_ready.

Test Plan:
- WIDTH=32, add 0x7FFFFFFF+1 -> one cycle later out_valid, result 0x80000000, overflow=1, isLessThan=0, isNotEqual=1.
- sub A=0x80000000, B=1 -> result 0x7FFFFFFF, overflow=1, isLessThan=1. sra A=0xF0000000 shamt=4 -> 0xFF000000.
- mul -7*6 -> in_ready low 32 cycles, out_valid at cycle 32, result 0xFFFFFFD6, overflow=0. mul 0x10000*0x10000 -> result 0, overflow=1.
- div -7/2 -> 0xFFFFFFFD. div 5/0 -> result 0, exception=1. div 0x80000000/-1 -> 0x80000000, overflow=1.
- Issue mul, then raise reset at iteration 10 -> no out_valid, in_ready=1 next cycle. Immediately issue add 3+4 -> result 7.
- Back-to-back: add accepted in the same cycle a div's out_valid pulses -> two consecutive out_valid pulses with correct results. Illegal opcode 01010 -> result 0, exception=1.
